// File: rtl/toggle_period_meter.sv
// toggle_period_meter
// Measures the rising-edge-to-rising-edge period of an asynchronous toggling
// input in clk cycles. It reports each period and whether it equalled
// `expected`, and flags an input that stops toggling.
//
// Output strobes: period_valid and timeout are single-cycle pulses with no
// back-pressure. period, match and edge_count are registered and hold
// between pulses, so they can be sampled whenever period_valid is high.
// Both strobes are driven from one exclusive branch, so they can never be
// high in the same cycle.
//
// Detection latency: if sig_in meets setup before clk edge N, the registered
// rise strobe is high in the cycle after edge N+2.
//
// state_dbg exposes the FSM state: 0 = IDLE, 1 = ARMED, 2 = MEASURE.
module toggle_period_meter #(
  parameter int          WIDTH   = 32,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sig_in,
  input  logic             enable,
  input  logic [WIDTH-1:0] expected,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             match,
  output logic             timeout,
  output logic [7:0]       edge_count,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] TIMEOUT_VAL = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  state_t           state, state_nxt;
  logic             sync1, sync2, hist, rise;
  logic [WIDTH-1:0] counter, counter_nxt;
  logic [WIDTH-1:0] period_nxt;
  logic             match_nxt, period_valid_nxt, timeout_nxt;
  logic [7:0]       edge_count_nxt;

  assign state_dbg = state;

  // Two-flop synchronizer, history flop, and registered rising-edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      hist  <= sync2;
      rise  <= sync2 & ~hist;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, counter and result updates.
  // enable=0 wins over everything, including a coincident rise.
  // In MEASURE a rise wins over the timeout.
  always_comb begin
    state_nxt        = state;
    counter_nxt      = counter;
    period_nxt       = period;
    match_nxt        = match;
    period_valid_nxt = 1'b0;
    timeout_nxt      = 1'b0;
    edge_count_nxt   = edge_count;
    if (!enable) begin
      state_nxt   = IDLE;
      counter_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt   = ARMED;
          counter_nxt = '0;
        end
        ARMED: begin
          // The first rise after arming only starts the measurement.
          if (rise) begin
            state_nxt   = MEASURE;
            counter_nxt = ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_nxt       = counter;
            match_nxt        = (counter == expected);
            period_valid_nxt = 1'b1;
            edge_count_nxt   = edge_count + 8'd1;
            counter_nxt      = ONE;
          end else if (counter == TIMEOUT_VAL) begin
            // The counter never passes TIMEOUT, so it cannot wrap.
            timeout_nxt = 1'b1;
            state_nxt   = ARMED;
            counter_nxt = '0;
          end else begin
            counter_nxt = counter + ONE;
          end
        end
        default: begin
          state_nxt   = IDLE;
          counter_nxt = '0;
        end
      endcase
    end
  end

  // Counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter      <= '0;
      period       <= '0;
      match        <= 1'b0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      edge_count   <= 8'd0;
    end else begin
      counter      <= counter_nxt;
      period       <= period_nxt;
      match        <= match_nxt;
      period_valid <= period_valid_nxt;
      timeout      <= timeout_nxt;
      edge_count   <= edge_count_nxt;
    end
  end

endmodule

// File: tb/tb_toggle_period_meter.sv
// Testbench for toggle_period_meter.
// The reference model works from timestamps: it keeps the clk edge of the
// last start rise and emits a period or a timeout from edge differences.
module tb_toggle_period_meter;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 20;
  localparam int EW      = 1 + WIDTH + 1 + 8;

  typedef struct packed {
    logic             is_to;
    logic [WIDTH-1:0] per;
    logic             mt;
    logic [7:0]       ec;
  } exp_t;

  // ---------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------
  logic             clk      = 1'b0;
  logic             reset_n  = 1'b0;
  logic             sig_in   = 1'b0;
  logic             enable   = 1'b0;
  logic [WIDTH-1:0] expected = '0;
  logic [WIDTH-1:0] period;
  logic             period_valid, match, timeout;
  logic [7:0]       edge_count;
  logic [1:0]       state_dbg;

  always #5 clk = ~clk;

  toggle_period_meter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sig_in       (sig_in),
    .enable       (enable),
    .expected     (expected),
    .period       (period),
    .period_valid (period_valid),
    .match        (match),
    .timeout      (timeout),
    .edge_count   (edge_count),
    .state_dbg    (state_dbg)
  );

  // ---------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, need %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------
  logic [3:0]       m_h;          // sig_in samples from edges e-1 .. e-4
  logic             m_prev_en;    // enable sampled on the previous edge
  logic             m_have_start; // a start rise has been seen
  int               m_edge;
  int               m_start;
  logic [WIDTH-1:0] m_period;
  logic             m_match;
  logic [7:0]       m_ec;

  always @(posedge clk or negedge reset_n) begin
    logic m_rise;
    exp_t e;
    if (!reset_n) begin
      m_h          = 4'b0;
      m_prev_en    = 1'b0;
      m_have_start = 1'b0;
      m_edge       = 0;
      m_start      = 0;
      m_period     = '0;
      m_match      = 1'b0;
      m_ec         = 8'd0;
      exp_q.delete();
    end else begin
      m_edge++;
      // A 0->1 step between the samples taken four and three edges ago is
      // acted on at this edge.
      m_rise = m_h[2] & ~m_h[3];
      if (!enable) begin
        m_have_start = 1'b0;
      end else if (m_prev_en) begin
        if (m_rise) begin
          if (m_have_start) begin
            m_period = WIDTH'(m_edge - m_start);
            m_match  = (m_period == expected);
            m_ec     = m_ec + 8'd1;
            e.is_to  = 1'b0;
            e.per    = m_period;
            e.mt     = m_match;
            e.ec     = m_ec;
            exp_q.push_back(e);
          end
          m_have_start = 1'b1;
          m_start      = m_edge;
        end else if (m_have_start && (m_edge - m_start) == TIMEOUT) begin
          e.is_to  = 1'b1;
          e.per    = m_period;
          e.mt     = m_match;
          e.ec     = m_ec;
          exp_q.push_back(e);
          m_have_start = 1'b0;
        end
      end
      m_prev_en = enable;
      m_h       = {m_h[2:0], sig_in};
    end
  end

  // ---------------------------------------------------------------
  // Monitor: pops expected pulses and checks the held outputs
  // ---------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (period_valid && timeout) chk("pulse_overlap", 32'd1, 32'd0);
      if (period_valid || timeout) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, period_valid, timeout}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", {31'd0, timeout}, {31'd0, e.is_to});
          chk("pulse_period", 32'(period), 32'(e.per));
          chk("pulse_match", {31'd0, match}, {31'd0, e.mt});
          chk("pulse_edge_count", 32'(edge_count), 32'(e.ec));
        end
      end else begin
        chk("missing_pulse", exp_q.size(), 32'd0);
        exp_q.delete();
      end
      chk("held_period", 32'(period), 32'(m_period));
      chk("held_match", {31'd0, match}, {31'd0, m_match});
      chk("held_edge_count", 32'(edge_count), 32'(m_ec));
    end
  end

  // ---------------------------------------------------------------
  // Driver tasks (inputs change on the falling edge)
  // ---------------------------------------------------------------
  task automatic idle(input int n);
    sig_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic gen(input int p, input int n);
    int hi;
    hi = (p / 2 > 0) ? p / 2 : 1;
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      repeat (hi) @(negedge clk);
      sig_in = 1'b0;
      repeat (p - hi) @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_period", 32'(period), 32'd0);
    chk("reset_valid", {31'd0, period_valid}, 32'd0);
    chk("reset_match", {31'd0, match}, 32'd0);
    chk("reset_timeout", {31'd0, timeout}, 32'd0);
    chk("reset_edge_count", 32'(edge_count), 32'd0);
    reset_n = 1'b1;

    // Toggle every 5 cycles, expected matches, then mismatches.
    enable   = 1'b1;
    expected = WIDTH'(10);
    idle(4);
    gen(10, 8);
    expected = WIDTH'(12);
    gen(10, 6);

    // Input stops after a rise: a single timeout.
    idle(35);

    // Rises spaced exactly TIMEOUT apart, then one cycle past it.
    expected = WIDTH'(TIMEOUT);
    gen(TIMEOUT, 4);
    gen(TIMEOUT + 1, 3);
    idle(30);

    // enable dropped mid-period, then re-raised.
    expected = WIDTH'(10);
    gen(10, 3);
    sig_in = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    sig_in = 1'b0;
    repeat (4) @(negedge clk);
    gen(10, 4);

    // Randomized bursts with enable drops and stalls.
    for (int k = 0; k < 60; k++) begin
      int p;
      p        = $urandom_range(2, 24);
      expected = ($urandom_range(0, 1) == 1) ? WIDTH'(p) : WIDTH'($urandom_range(2, 24));
      if ($urandom_range(0, 4) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        enable = 1'b1;
      end
      gen(p, $urandom_range(1, 6));
      if ($urandom_range(0, 5) == 0) idle($urandom_range(15, 30));
    end

    // Asynchronous reset mid-measurement, then 256 measurements.
    expected = WIDTH'(5);
    gen(10, 3);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    sig_in  = 1'b0;
    #1;
    chk("async_period", 32'(period), 32'd0);
    chk("async_valid", {31'd0, period_valid}, 32'd0);
    chk("async_match", {31'd0, match}, 32'd0);
    chk("async_timeout", {31'd0, timeout}, 32'd0);
    chk("async_edge_count", 32'(edge_count), 32'd0);
    #3;
    reset_n = 1'b1;
    @(negedge clk);
    idle(4);
    gen(5, 257);
    idle(5);
    chk("edge_count_wrap", 32'(edge_count), 32'd0);
    chk("wrap_period", 32'(period), 32'd5);

    idle(30);
    chk("queue_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/toggle_period_meter.md
TOGGLE_PERIOD_METER -- requirements
Module: toggle_period_meter

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 32, giving the width of the period counter and result.
REQ-002 The block SHALL have the parameter TIMEOUT, default 1000, giving the maximum number of clk cycles without a rising edge; legal range 2 to 2^WIDTH-1.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have the port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have the port sig_in, input, 1 bit: asynchronous toggling signal to measure, such as a LED or divider output.
REQ-006 The block SHALL have the port enable, input, 1 bit: level; 1 runs measurement and 0 forces idle.
REQ-007 The block SHALL have the port expected, input, WIDTH bits: reference period in clk cycles, sampled at each measurement completion.
REQ-008 The block SHALL have the port period, output, WIDTH bits: last measured rising-edge-to-rising-edge period in clk cycles.
REQ-009 The block SHALL have the port period_valid, output, 1 bit: one-cycle pulse when period is updated.
REQ-010 The block SHALL have the port match, output, 1 bit: 1 when the last period equalled expected; held until the next measurement.
REQ-011 The block SHALL have the port timeout, output, 1 bit: one-cycle pulse when TIMEOUT elapses without a rising edge.
REQ-012 The block SHALL have the port edge_count, output, 8 bits: count of completed measurements, which wraps from 255 to 0.

Function
REQ-013 sig_in SHALL pass through a 2-flop synchronizer followed by a history flop; rise = sync AND NOT history.
REQ-014 A sig_in rising edge that meets setup before clk edge N SHALL produce rise asserted in the cycle after clk edge N+2.
REQ-015 The FSM SHALL have the states IDLE, ARMED and MEASURE.
REQ-016 In IDLE with enable=1, the FSM SHALL go to ARMED on the next clk edge.
REQ-017 In any state, enable=0 SHALL force IDLE on the next clk edge and clear the counter; period, match and edge_count SHALL hold.
REQ-018 In ARMED, rise SHALL move the FSM to MEASURE with the counter loaded to 1; without rise, the FSM SHALL remain in ARMED.
REQ-019 In MEASURE without rise, the counter SHALL increment by 1 each cycle.
REQ-020 In MEASURE with rise, the block SHALL load period <= counter and match <= (counter == expected), pulse period_valid, increment edge_count, reload the counter to 1 and stay in MEASURE.
REQ-021 The reported period SHALL equal the exact number of clk cycles between consecutive detected rises.
REQ-022 In MEASURE, when counter == TIMEOUT and rise is 0, the block SHALL pulse timeout, leave period and match unchanged, and go to ARMED.
REQ-023 When rise coincides with counter == TIMEOUT, the measurement SHALL win: period = TIMEOUT, period_valid pulses and timeout stays 0.
REQ-024 The counter SHALL never wrap; the TIMEOUT bound guarantees this.
REQ-025 When enable falls in the same cycle as rise, IDLE SHALL win and no period_valid SHALL be generated.
REQ-026 period_valid and timeout SHALL never both be 1 in the same cycle.

Reset
REQ-027 reset_n=0 SHALL asynchronously set: FSM=IDLE, synchronizer and history flops=0, counter=0, period=0, period_valid=0, match=0, timeout=0, edge_count=0.
REQ-028 Reset asserted mid-measurement SHALL abort with no pulse output; after release, the block SHALL re-arm and discard the first edge as a start edge.
REQ-029 Outputs SHALL leave reset values only on clk edges after reset_n returns to 1.

Verification
REQ-030 sig_in toggling every 5 clk cycles, expected=10, enable=1 -> from the second rise onward, period=10, match=1 and period_valid pulses every 10 cycles.
REQ-031 Same stimulus with expected=12 -> period=10, match=0, edge_count increments per pulse.
REQ-032 sig_in held at 0 after one rise, TIMEOUT=20 -> a single timeout pulse 20 cycles after the rise; FSM returns to ARMED with period unchanged.
REQ-033 A rise arriving exactly at counter==TIMEOUT -> period=TIMEOUT, period_valid=1, timeout=0.
REQ-034 enable dropped mid-period, then re-raised -> no period_valid until two further rises; period holds the old value meanwhile.
REQ-035 reset_n pulsed low asynchronously between clk edges during MEASURE -> all outputs 0 immediately; 256 measurements after release -> edge_count wraps back to 0.
